// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port RAM between the CPU memory path and a
// DMA/loader requester.
//   IDLE   : sample CPU_REQ/DMA_REQ, pick a winner, latch its WE/ADDR/WDATA
//   ACCESS : drive the RAM from the latched request for max(WAIT_CYCLES,1) cycles
//   DONE   : one-cycle ACK to the owner, RAM idle
// Ports:
//   CLK, RESET                       clock (rising edge), async active-high reset
//   CPU_REQ/WE/ADDR/WDATA            CPU request, held until CPU_ACK
//   CPU_ACK, CPU_RDATA               completion pulse, read data (held to next read)
//   DMA_*                            same as CPU_* for the DMA requester
//   MEM_ADDR/WE/DIN                  RAM drive, zero outside ACCESS
//   MEM_DOUT                         RAM combinational read data
//   BUSY                             high in ACCESS and DONE
//   OWNER                            current/last grant (0 = CPU, 1 = DMA)
module mem_port_arbiter #(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned CPU_PRIORITY = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_ACK,
  output logic [DW-1:0] CPU_RDATA,
  input  logic          DMA_REQ,
  input  logic          DMA_WE,
  input  logic [AW-1:0] DMA_ADDR,
  input  logic [DW-1:0] DMA_WDATA,
  output logic          DMA_ACK,
  output logic [DW-1:0] DMA_RDATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_DIN,
  input  logic [DW-1:0] MEM_DOUT,
  output logic          BUSY,
  output logic          OWNER
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Wait counter is 4 bits; WAIT_CYCLES of 0 behaves as 1.
  localparam int unsigned CW       = 4;
  localparam int unsigned WAIT_EFF = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_EFF - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          owner_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic          mem_we_nxt;
  logic [DW-1:0] mem_din_nxt;
  logic          cpu_ack_nxt;
  logic          dma_ack_nxt;
  logic [DW-1:0] cpu_rdata_nxt;
  logic [DW-1:0] dma_rdata_nxt;
  logic          busy_nxt;
  logic          grant_dma_c;

  // Winner selection: a lone requester always wins; on a tie either the CPU
  // wins outright or the grant alternates away from the last owner.
  always_comb begin
    grant_dma_c = DMA_REQ;
    if (CPU_REQ && DMA_REQ) begin
      if (CPU_PRIORITY != 0) grant_dma_c = 1'b0;
      else                   grant_dma_c = ~OWNER;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    owner_nxt     = OWNER;
    mem_addr_nxt  = MEM_ADDR;
    mem_we_nxt    = MEM_WE;
    mem_din_nxt   = MEM_DIN;
    cpu_ack_nxt   = 1'b0;
    dma_ack_nxt   = 1'b0;
    cpu_rdata_nxt = CPU_RDATA;
    dma_rdata_nxt = DMA_RDATA;
    busy_nxt      = BUSY;

    case (state)
      IDLE: begin
        mem_addr_nxt = '0;
        mem_we_nxt   = 1'b0;
        mem_din_nxt  = '0;
        busy_nxt     = 1'b0;
        if (CPU_REQ || DMA_REQ) begin
          // The MEM_* registers double as the latched request for ACCESS.
          state_nxt = ACCESS;
          cnt_nxt   = CNT_LOAD;
          owner_nxt = grant_dma_c;
          busy_nxt  = 1'b1;
          if (grant_dma_c) begin
            mem_addr_nxt = DMA_ADDR;
            mem_we_nxt   = DMA_WE;
            mem_din_nxt  = DMA_WDATA;
          end else begin
            mem_addr_nxt = CPU_ADDR;
            mem_we_nxt   = CPU_WE;
            mem_din_nxt  = CPU_WDATA;
          end
        end
      end

      ACCESS: begin
        busy_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt    = DONE;
          mem_addr_nxt = '0;
          mem_we_nxt   = 1'b0;
          mem_din_nxt  = '0;
          // Last RAM cycle: reads capture the RAM output for the owner only.
          if (OWNER) begin
            dma_ack_nxt = 1'b1;
            if (!MEM_WE) dma_rdata_nxt = MEM_DOUT;
          end else begin
            cpu_ack_nxt = 1'b1;
            if (!MEM_WE) cpu_rdata_nxt = MEM_DOUT;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      DONE: begin
        state_nxt    = IDLE;
        busy_nxt     = 1'b0;
        mem_addr_nxt = '0;
        mem_we_nxt   = 1'b0;
        mem_din_nxt  = '0;
      end

      default: begin
        state_nxt    = IDLE;
        busy_nxt     = 1'b0;
        mem_addr_nxt = '0;
        mem_we_nxt   = 1'b0;
        mem_din_nxt  = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any access with no ACK.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      OWNER     <= 1'b1;
      MEM_ADDR  <= '0;
      MEM_WE    <= 1'b0;
      MEM_DIN   <= '0;
      CPU_ACK   <= 1'b0;
      DMA_ACK   <= 1'b0;
      CPU_RDATA <= '0;
      DMA_RDATA <= '0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      OWNER     <= owner_nxt;
      MEM_ADDR  <= mem_addr_nxt;
      MEM_WE    <= mem_we_nxt;
      MEM_DIN   <= mem_din_nxt;
      CPU_ACK   <= cpu_ack_nxt;
      DMA_ACK   <= dma_ack_nxt;
      CPU_RDATA <= cpu_rdata_nxt;
      DMA_RDATA <= dma_rdata_nxt;
      BUSY      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances share one stimulus set.
//   a: WAIT_CYCLES=1, round-robin   b: WAIT_CYCLES=3, round-robin
//   c: WAIT_CYCLES=1, CPU priority
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
  logic [15:0] mem_dout = '0;

  logic        a_cpu_ack, a_dma_ack, a_mem_we, a_busy, a_owner;
  logic [15:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_din;
  logic        b_cpu_ack, b_dma_ack, b_mem_we, b_busy, b_owner;
  logic [15:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_din;
  logic        c_cpu_ack, c_dma_ack, c_mem_we, c_busy, c_owner;
  logic [15:0] c_cpu_rdata, c_dma_rdata, c_mem_addr, c_mem_din;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(1), .CPU_PRIORITY(0)) u_a (
    .CLK(CLK), .RESET(RESET),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_ACK(a_cpu_ack), .CPU_RDATA(a_cpu_rdata),
    .DMA_REQ(dma_req), .DMA_WE(dma_we), .DMA_ADDR(dma_addr), .DMA_WDATA(dma_wdata),
    .DMA_ACK(a_dma_ack), .DMA_RDATA(a_dma_rdata),
    .MEM_ADDR(a_mem_addr), .MEM_WE(a_mem_we), .MEM_DIN(a_mem_din), .MEM_DOUT(mem_dout),
    .BUSY(a_busy), .OWNER(a_owner));

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(3), .CPU_PRIORITY(0)) u_b (
    .CLK(CLK), .RESET(RESET),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_ACK(b_cpu_ack), .CPU_RDATA(b_cpu_rdata),
    .DMA_REQ(dma_req), .DMA_WE(dma_we), .DMA_ADDR(dma_addr), .DMA_WDATA(dma_wdata),
    .DMA_ACK(b_dma_ack), .DMA_RDATA(b_dma_rdata),
    .MEM_ADDR(b_mem_addr), .MEM_WE(b_mem_we), .MEM_DIN(b_mem_din), .MEM_DOUT(mem_dout),
    .BUSY(b_busy), .OWNER(b_owner));

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(1), .CPU_PRIORITY(1)) u_c (
    .CLK(CLK), .RESET(RESET),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_ACK(c_cpu_ack), .CPU_RDATA(c_cpu_rdata),
    .DMA_REQ(dma_req), .DMA_WE(dma_we), .DMA_ADDR(dma_addr), .DMA_WDATA(dma_wdata),
    .DMA_ACK(c_dma_ack), .DMA_RDATA(c_dma_rdata),
    .MEM_ADDR(c_mem_addr), .MEM_WE(c_mem_we), .MEM_DIN(c_mem_din), .MEM_DOUT(mem_dout),
    .BUSY(c_busy), .OWNER(c_owner));

  // One cycle of instance a: requests applied, expected outputs after the edge.
  // CPU request is always a read of 0x3000; DMA is always a write 0x4000<=0x1234.
  typedef struct {
    logic        creq;
    logic        dreq;
    logic        e_cack;
    logic        e_dack;
    logic        e_mwe;
    logic [15:0] e_maddr;
    logic [15:0] e_mdin;
    logic        e_busy;
    logic        e_owner;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Follows one access on instance b: counts ACCESS cycles whose RAM drive
  // matches, records the cycle of the requester's ACK, drops requests on ACK.
  task automatic measure_b(input logic is_dma, input logic [15:0] ea, input logic [15:0] ed,
                           input logic ewe, input logic chg,
                           output int ack_cyc, output int acc_cnt, output int other_acks);
    logic ack;
    ack_cyc = -1; acc_cnt = 0; other_acks = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge CLK); #1;
      if (b_busy && !b_cpu_ack && !b_dma_ack &&
          b_mem_addr == ea && b_mem_din == ed && b_mem_we == ewe)
        acc_cnt++;
      ack = is_dma ? b_dma_ack : b_cpu_ack;
      if (is_dma ? b_cpu_ack : b_dma_ack) other_acks++;
      if (chg && c == 1) cpu_addr = 16'h5000;
      if (ack) begin
        ack_cyc = c;
        chk("done_mem_we", 32'(b_mem_we), 32'd0);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int ack_cyc, acc_cnt, other, n_cpu, n_dma, a1, a2;

    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h1234, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vt[6]  = vt[0];
    vt[7]  = vt[1];
    vt[8]  = vt[2];
    vt[9]  = vt[3];
    vt[10] = vt[4];
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};

    // Reset values
    do_reset();
    chk("rst_owner",  32'(a_owner),     32'd1);
    chk("rst_busy",   32'(a_busy),      32'd0);
    chk("rst_mem_we", 32'(a_mem_we),    32'd0);
    chk("rst_addr",   32'(a_mem_addr),  32'd0);
    chk("rst_ack",    32'(a_cpu_ack),   32'd0);
    chk("rst_rdata",  32'(a_cpu_rdata), 32'd0);

    // Table: W=1 round-robin, both requesters held -> CPU, DMA, CPU, DMA
    mem_dout  = 16'hABCD;
    cpu_we    = 1'b0; cpu_addr = 16'h3000; cpu_wdata = 16'h0000;
    dma_we    = 1'b1; dma_addr = 16'h4000; dma_wdata = 16'h1234;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      cpu_req = vt[i].creq;
      dma_req = vt[i].dreq;
      @(posedge CLK); #1;
      chk($sformatf("v%0d_cpu_ack", i), 32'(a_cpu_ack),  32'(vt[i].e_cack));
      chk($sformatf("v%0d_dma_ack", i), 32'(a_dma_ack),  32'(vt[i].e_dack));
      chk($sformatf("v%0d_mem_we", i),  32'(a_mem_we),   32'(vt[i].e_mwe));
      chk($sformatf("v%0d_addr", i),    32'(a_mem_addr), 32'(vt[i].e_maddr));
      chk($sformatf("v%0d_din", i),     32'(a_mem_din),  32'(vt[i].e_mdin));
      chk($sformatf("v%0d_busy", i),    32'(a_busy),     32'(vt[i].e_busy));
      chk($sformatf("v%0d_owner", i),   32'(a_owner),    32'(vt[i].e_owner));
    end
    chk("tbl_cpu_rdata", 32'(a_cpu_rdata), 32'hABCD);
    chk("tbl_dma_rdata", 32'(a_dma_rdata), 32'd0);

    // W=3 DMA write: MEM_WE exactly 3 cycles, ACK in cycle 4
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h4000; dma_wdata = 16'h1234;
    measure_b(1'b1, 16'h4000, 16'h1234, 1'b1, 1'b0, ack_cyc, acc_cnt, other);
    chk("w3_ack_cycle", 32'(ack_cyc), 32'd4);
    chk("w3_we_cycles", 32'(acc_cnt), 32'd3);
    chk("w3_cpu_ack",   32'(other),   32'd0);

    // W=3 CPU read, address changed one cycle after grant
    do_reset();
    mem_dout = 16'h7777;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000; cpu_wdata = 16'h0000;
    measure_b(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b1, ack_cyc, acc_cnt, other);
    chk("chg_ack_cycle",  32'(ack_cyc),     32'd4);
    chk("chg_addr_held",  32'(acc_cnt),     32'd3);
    chk("chg_cpu_rdata",  32'(b_cpu_rdata), 32'h7777);
    chk("chg_dma_rdata",  32'(b_dma_rdata), 32'd0);

    // Reset in the 2nd ACCESS cycle of a W=3 write, then a normal access
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h4000; dma_wdata = 16'h1234;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("abort_we_before", 32'(b_mem_we), 32'd1);
    #1 RESET = 1'b1;
    #1;
    chk("abort_mem_we", 32'(b_mem_we),  32'd0);
    chk("abort_busy",   32'(b_busy),    32'd0);
    chk("abort_ack",    32'(b_dma_ack), 32'd0);
    dma_req = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h5000; cpu_wdata = 16'h00FF;
    measure_b(1'b0, 16'h5000, 16'h00FF, 1'b1, 1'b0, ack_cyc, acc_cnt, other);
    chk("post_ack_cycle", 32'(ack_cyc), 32'd4);
    chk("post_we_cycles", 32'(acc_cnt), 32'd3);
    chk("post_dma_ack",   32'(other),   32'd0);

    // Both held for 12 cycles: priority instance serves only the CPU,
    // round-robin instance alternates.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h4000; dma_wdata = 16'h1234;
    n_cpu = 0; n_dma = 0; a1 = 0; a2 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge CLK); #1;
      if (c_cpu_ack) n_cpu++;
      if (c_dma_ack) n_dma++;
      if (a_cpu_ack) a1++;
      if (a_dma_ack) a2++;
    end
    chk("pri_cpu_acks", 32'(n_cpu), 32'd4);
    chk("pri_dma_acks", 32'(n_dma), 32'd0);
    chk("rr_cpu_acks",  32'(a1),    32'd2);
    chk("rr_dma_acks",  32'(a2),    32'd2);

    // W=1 CPU holds REQ through ACK: ACKs in cycles 2 and 5
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    a1 = -1; a2 = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (a_cpu_ack) begin
        if (a1 < 0) a1 = c;
        else begin
          a2 = c;
          cpu_req = 1'b0;
        end
      end
    end
    chk("hold_ack1", 32'(a1), 32'd2);
    chk("hold_ack2", 32'(a2), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
